// File: rtl/cmd_rx_pkg.sv
// cmd_rx_pkg: shared FSM states and command byte codes for the command frame receiver
package cmd_rx_pkg;
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_CMD, S_PAYLOAD, S_CHECK, S_HOLD} state_t;
  localparam logic [7:0] CMD_START = 8'd49;
  localparam logic [7:0] CMD_STOP  = 8'd48;
  localparam logic [7:0] CMD_PING  = 8'd112;
  localparam logic [7:0] CMD_NONCE = 8'd110;
endpackage

// File: rtl/cmd_frame_receiver_if.sv
// cmd_frame_receiver_if: byte-in / command-and-nonce-out bundle of the command frame receiver
interface cmd_frame_receiver_if #(parameter int NONCE_BYTES = 8);
  logic                     new_data_i;
  logic [7:0]               data_i;
  logic                     nonce_ready_i;
  logic                     start_o;
  logic                     stop_o;
  logic                     ping_o;
  logic                     nonce_valid_o;
  logic [8*NONCE_BYTES-1:0] nonce_o;
  logic                     busy_o;
  logic                     error_o;
  modport master (output new_data_i, data_i, nonce_ready_i,
                  input start_o, stop_o, ping_o, nonce_valid_o, nonce_o, busy_o, error_o);
  modport slave  (input new_data_i, data_i, nonce_ready_i,
                  output start_o, stop_o, ping_o, nonce_valid_o, nonce_o, busy_o, error_o);
endinterface

// File: rtl/cmd_frame_receiver_timeout.sv
// idle_timeout_counter: counts idle cycles while enabled and flags when CYCLES-1 is reached
module idle_timeout_counter #(
  parameter int CYCLES = 1000000,
  parameter int W      = $clog2(CYCLES)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  logic [W-1:0] cnt;
  assign expired_o = cnt == W'(CYCLES - 1);
  // clear wins over counting; saturate once expired so the flag cannot wrap away
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else if (clear_i) cnt <= '0;
    else if (enable_i && !expired_o) cnt <= cnt + W'(1);
endmodule

// File: rtl/cmd_frame_receiver.sv
// cmd_frame_receiver: header/command parser with nonce capture; CMD_CHECKSUM_EN adds an XOR check byte
module cmd_frame_receiver import cmd_rx_pkg::*; #(
  parameter logic [7:0] HDR0           = 8'd100,
  parameter logic [7:0] HDR1           = 8'd52,
  parameter int         NONCE_BYTES    = 8,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input logic clk_i,
  input logic rst_i,
  cmd_frame_receiver_if.slave bus
);
  localparam int NW = 8 * NONCE_BYTES;
  localparam int CW = $clog2(NONCE_BYTES) + 1;
  state_t st, nxt;
  logic [NW-1:0] shadow_q, shadow_d, nonce_q, nonce_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, start_q, start_d, stop_q, stop_d, ping_q, ping_d, err_q, err_d, busy_q;
  logic [7:0] d;
  logic counting, expired, to;
`ifdef CMD_CHECKSUM_EN
  logic [7:0] cmd_q, cmd_d, sum_q, sum_d;
  logic ok, load;
`endif
  assign d        = bus.data_i;
  assign counting = st inside {S_HDR1, S_CMD, S_PAYLOAD, S_CHECK};
  assign to       = expired && counting;
  idle_timeout_counter #(.CYCLES(TIMEOUT_CYCLES), .W(TO_W)) u_timeout (
    .clk_i(clk_i), .rst_i(rst_i),
    .clear_i((bus.new_data_i && st != S_HOLD) || nxt != st),
    .enable_i(counting), .expired_o(expired)
  );
  // next-state and next-output decode; a timeout overrides any byte arriving that cycle
  always_comb begin
    nxt = st;
    shadow_d = shadow_q;
    nonce_d = nonce_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    start_d = 1'b0;
    stop_d = 1'b0;
    ping_d = 1'b0;
    err_d = 1'b0;
`ifdef CMD_CHECKSUM_EN
    cmd_d = cmd_q;
    sum_d = sum_q;
    ok = d == sum_q;
    load = ok && cmd_q == CMD_NONCE;
`endif
    if (to) begin
      nxt = S_HDR0;
      err_d = 1'b1;
    end else case (st)
      S_HDR0: nxt = bus.new_data_i && d == HDR0 ? S_HDR1 : S_HDR0;
      S_HDR1: if (bus.new_data_i) nxt = d == HDR1 ? S_CMD : d == HDR0 ? S_HDR1 : S_HDR0;
      S_CMD: if (bus.new_data_i) begin
        err_d = !(d inside {CMD_START, CMD_STOP, CMD_PING, CMD_NONCE});
        cnt_d = '0;
`ifdef CMD_CHECKSUM_EN
        cmd_d = d;
        sum_d = d;
        nxt = err_d ? S_HDR0 : d == CMD_NONCE ? S_PAYLOAD : S_CHECK;
`else
        start_d = d == CMD_START;
        stop_d = d == CMD_STOP;
        ping_d = d == CMD_PING;
        nxt = d == CMD_NONCE ? S_PAYLOAD : S_HDR0;
`endif
      end
      S_PAYLOAD: if (bus.new_data_i) begin
        shadow_d = (shadow_q << 8) | NW'(d);
        cnt_d = cnt_q + CW'(1);
`ifdef CMD_CHECKSUM_EN
        sum_d = sum_q ^ d;
        if (cnt_q == CW'(NONCE_BYTES - 1)) nxt = S_CHECK;
`else
        if (cnt_q == CW'(NONCE_BYTES - 1)) begin
          nonce_d = shadow_d;
          valid_d = 1'b1;
          nxt = S_HOLD;
        end
`endif
      end
`ifdef CMD_CHECKSUM_EN
      S_CHECK: if (bus.new_data_i) begin
        start_d = ok && cmd_q == CMD_START;
        stop_d = ok && cmd_q == CMD_STOP;
        ping_d = ok && cmd_q == CMD_PING;
        err_d = !ok;
        nonce_d = load ? shadow_q : nonce_q;
        valid_d = load;
        nxt = load ? S_HOLD : S_HDR0;
      end
`endif
      S_HOLD: if (bus.nonce_ready_i) begin
        valid_d = 1'b0;
        nxt = S_HDR0;
      end
      default: nxt = S_HDR0;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      st <= S_HDR0;
      shadow_q <= '0;
      nonce_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      ping_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      cmd_q <= '0;
      sum_q <= '0;
`endif
    end else begin
      st <= nxt;
      shadow_q <= shadow_d;
      nonce_q <= nonce_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      start_q <= start_d;
      stop_q <= stop_d;
      ping_q <= ping_d;
      err_q <= err_d;
      busy_q <= nxt != S_HDR0;
`ifdef CMD_CHECKSUM_EN
      cmd_q <= cmd_d;
      sum_q <= sum_d;
`endif
    end
  assign bus.start_o       = start_q;
  assign bus.stop_o        = stop_q;
  assign bus.ping_o        = ping_q;
  assign bus.error_o       = err_q;
  assign bus.busy_o        = busy_q;
  assign bus.nonce_valid_o = valid_q;
  assign bus.nonce_o       = nonce_q;
endmodule

// File: tb/tb_cmd_frame_receiver.sv
// tb_cmd_frame_receiver: scoreboard bench for cmd_frame_receiver (NONCE_BYTES=4, TIMEOUT_CYCLES=16)
module tb_cmd_frame_receiver;
  import cmd_rx_pkg::*;
  localparam int NB = 4;
  localparam int TO = 16;
  typedef struct {int code; logic [31:0] nonce;} exp_t;
  exp_t sb[$];
  exp_t m_e;
  int m_code;
  int total = 0;
  int bad = 0;
  logic clk = 0;
  logic rst = 1;
  logic valid_d = 0;
  always #5 clk = ~clk;
  cmd_frame_receiver_if #(.NONCE_BYTES(NB)) bus();
  cmd_frame_receiver #(.NONCE_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // every pulse or rising nonce_valid_o is one event that must match the head of the scoreboard
  // codes: 1 start, 2 stop, 3 ping, 4 error, 5 nonce
  always @(negedge clk) begin
    if (rst) valid_d = 0;
    else begin
      if (bus.start_o || bus.stop_o || bus.ping_o || bus.error_o || (bus.nonce_valid_o && !valid_d)) begin
        m_code = bus.start_o ? 1 : bus.stop_o ? 2 : bus.ping_o ? 3 : bus.error_o ? 4 : 5;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got code=%0d nonce=%h, required no event", m_code, bus.nonce_o);
        end else begin
          m_e = sb.pop_front();
          if (m_code != m_e.code || (m_code == 5 && bus.nonce_o !== m_e.nonce)) begin
            bad++;
            $display("FAIL sb_event: got code=%0d nonce=%h, required code=%0d nonce=%h",
                     m_code, bus.nonce_o, m_e.code, m_e.nonce);
          end
        end
      end
      valid_d = bus.nonce_valid_o;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.new_data_i = 1;
    bus.data_i = b;
    @(negedge clk);
    bus.new_data_i = 0;
  endtask

  task automatic frame(input logic [7:0] cmd, input int n, input logic [31:0] pl);
    send(8'd100);
    send(8'd52);
    send(cmd);
    for (int i = n - 1; i >= 0; i--) send(pl[8*i+:8]);
`ifdef CMD_CHECKSUM_EN
    begin
      logic [7:0] s;
      s = cmd;
      for (int i = 0; i < n; i++) s ^= pl[8*i+:8];
      send(s);
    end
`endif
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.start_o, bus.stop_o, bus.ping_o, bus.nonce_valid_o, bus.busy_o, bus.error_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 000000",
               {bus.start_o, bus.stop_o, bus.ping_o, bus.nonce_valid_o, bus.busy_o, bus.error_o});
    end
    total++;
    if (bus.nonce_o !== 32'h0) begin bad++; $display("FAIL reset_nonce: got %h required 0", bus.nonce_o); end
    rst = 0;
  endtask

  task automatic test_start;
    sb.push_back('{code: 1, nonce: 32'h0});
    frame(CMD_START, 0, 0);
    total++;
    if (bus.start_o !== 1'b1) begin bad++; $display("FAIL start_pulse: got %b required 1", bus.start_o); end
    total++;
    if (bus.busy_o !== 1'b0 || bus.error_o !== 1'b0) begin
      bad++;
      $display("FAIL start_idle: got busy=%b error=%b required 0 0", bus.busy_o, bus.error_o);
    end
    @(negedge clk);
    total++;
    if (bus.start_o !== 1'b0) begin bad++; $display("FAIL start_single: got %b required 0", bus.start_o); end
  endtask

  task automatic test_ping_stop;
    sb.push_back('{code: 3, nonce: 32'h0});
    send(8'd100);
    frame(CMD_PING, 0, 0);
    total++;
    if (bus.ping_o !== 1'b1) begin bad++; $display("FAIL ping_resync: got %b required 1", bus.ping_o); end
    sb.push_back('{code: 2, nonce: 32'h0});
    frame(CMD_STOP, 0, 0);
    total++;
    if (bus.stop_o !== 1'b1) begin bad++; $display("FAIL stop_pulse: got %b required 1", bus.stop_o); end
  endtask

  task automatic test_bad_cmd;
    sb.push_back('{code: 4, nonce: 32'h0});
    send(8'd100);
    send(8'd52);
    send(8'd120);
    total++;
    if ({bus.error_o, bus.start_o, bus.stop_o, bus.ping_o} !== 4'b1000) begin
      bad++;
      $display("FAIL bad_cmd: got err/start/stop/ping=%b required 1000",
               {bus.error_o, bus.start_o, bus.stop_o, bus.ping_o});
    end
  endtask

  task automatic test_nonce_hold;
    logic [7:0] extra[5] = '{8'd100, 8'd52, 8'd49, 8'd100, 8'd52};
    sb.push_back('{code: 5, nonce: 32'h12345678});
    frame(CMD_NONCE, NB, 32'h12345678);
    total++;
    if (bus.nonce_valid_o !== 1'b1 || bus.nonce_o !== 32'h12345678) begin
      bad++;
      $display("FAIL nonce_capture: got valid=%b nonce=%h required 1 12345678", bus.nonce_valid_o, bus.nonce_o);
    end
    foreach (extra[i]) begin
      send(extra[i]);
      total++;
      if (bus.nonce_valid_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.nonce_o !== 32'h12345678) begin
        bad++;
        $display("FAIL nonce_hold%0d: got valid=%b busy=%b nonce=%h required 1 1 12345678",
                 i, bus.nonce_valid_o, bus.busy_o, bus.nonce_o);
      end
    end
    bus.nonce_ready_i = 1;
    @(negedge clk);
    bus.nonce_ready_i = 0;
    total++;
    if (bus.nonce_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.nonce_o !== 32'h12345678) begin
      bad++;
      $display("FAIL nonce_accept: got valid=%b busy=%b nonce=%h required 0 0 12345678",
               bus.nonce_valid_o, bus.busy_o, bus.nonce_o);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    sb.push_back('{code: 4, nonce: 32'h0});
    send(8'd100);
    send(8'd52);
    send(CMD_NONCE);
    send(8'hAA);
    while (bus.error_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != TO) begin bad++; $display("FAIL timeout_latency: got %0d cycles required %0d", n, TO); end
    total++;
    if (bus.busy_o !== 1'b0 || bus.nonce_valid_o !== 1'b0 || bus.nonce_o !== 32'h12345678) begin
      bad++;
      $display("FAIL timeout_state: got busy=%b valid=%b nonce=%h required 0 0 12345678",
               bus.busy_o, bus.nonce_valid_o, bus.nonce_o);
    end
  endtask

  task automatic test_timeout_collision;
    sb.push_back('{code: 4, nonce: 32'h0});
    send(8'd100);
    send(8'd52);
    repeat (TO - 2) @(negedge clk);
    send(CMD_START);
    total++;
    if (bus.error_o !== 1'b1 || bus.start_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_collision: got error=%b start=%b required 1 0", bus.error_o, bus.start_o);
    end
    @(negedge clk);
    total++;
    if (bus.start_o !== 1'b0) begin bad++; $display("FAIL collision_nostart: got %b required 0", bus.start_o); end
  endtask

  task automatic test_reset_midframe;
    send(8'd100);
    send(8'd52);
    send(CMD_NONCE);
    send(8'h01);
    @(negedge clk);
    bus.new_data_i = 1;
    bus.data_i = 8'h02;
    total++;
    if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL midframe_busy: got %b required 1", bus.busy_o); end
    #1 rst = 1;
    #1;
    total++;
    if ({bus.start_o, bus.stop_o, bus.ping_o, bus.nonce_valid_o, bus.busy_o, bus.error_o} !== 6'b0
        || bus.nonce_o !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: got flags=%b nonce=%h required 000000 0",
               {bus.start_o, bus.stop_o, bus.ping_o, bus.nonce_valid_o, bus.busy_o, bus.error_o}, bus.nonce_o);
    end
    bus.new_data_i = 0;
    @(negedge clk);
    rst = 0;
    sb.push_back('{code: 1, nonce: 32'h0});
    frame(CMD_START, 0, 0);
    total++;
    if (bus.start_o !== 1'b1) begin bad++; $display("FAIL reset_recover: got %b required 1", bus.start_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pl = $urandom;
    bus.nonce_ready_i = 1;
    sb.push_back('{code: 5, nonce: pl});
    frame(CMD_NONCE, NB, pl);
    total++;
    if (bus.nonce_valid_o !== 1'b1 || bus.nonce_o !== pl) begin
      bad++;
      $display("FAIL b2b_capture: got valid=%b nonce=%h required 1 %h", bus.nonce_valid_o, bus.nonce_o, pl);
    end
    @(negedge clk);
    bus.nonce_ready_i = 0;
    total++;
    if (bus.nonce_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_accept: got %b required 0", bus.nonce_valid_o); end
    sb.push_back('{code: 3, nonce: 32'h0});
    frame(CMD_PING, 0, 0);
    total++;
    if (bus.ping_o !== 1'b1 || bus.nonce_o !== pl) begin
      bad++;
      $display("FAIL b2b_ping: got ping=%b nonce=%h required 1 %h", bus.ping_o, bus.nonce_o, pl);
    end
  endtask

`ifdef CMD_CHECKSUM_EN
  task automatic test_checksum;
    sb.push_back('{code: 1, nonce: 32'h0});
    send(8'd100); send(8'd52); send(8'd49); send(8'h31);
    total++;
    if (bus.start_o !== 1'b1) begin bad++; $display("FAIL csum_ok: got %b required 1", bus.start_o); end
    sb.push_back('{code: 4, nonce: 32'h0});
    send(8'd100); send(8'd52); send(8'd49); send(8'h30);
    total++;
    if (bus.error_o !== 1'b1 || bus.start_o !== 1'b0) begin
      bad++;
      $display("FAIL csum_bad: got error=%b start=%b required 1 0", bus.error_o, bus.start_o);
    end
  endtask
`endif

  initial begin
    bus.new_data_i = 0;
    bus.data_i = 0;
    bus.nonce_ready_i = 0;
    test_reset;
    test_start;
    test_ping_stop;
    test_bad_cmd;
    test_nonce_hold;
    test_timeout;
    test_timeout_collision;
    test_reset_midframe;
    test_back_to_back;
`ifdef CMD_CHECKSUM_EN
    test_checksum;
`endif
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns required finish");
    $fatal(1);
  end
endmodule

// File: doc/cmd_frame_receiver.md
Name: cmd_frame_receiver

Overview:
- Parametrised successor of the host-link command parser; sits between the UART byte receiver and the hash-search control/nonce datapath.
- Detects a two-byte header, decodes one command byte, and for the nonce command captures a NONCE_BYTES payload.
- Owns its inter-byte timeout counter internally and issues a downstream valid/ready handshake for the captured nonce.

Parameters:
- HDR0, 8'd100 ('d'), first header byte
- HDR1, 8'd52 ('4'), second header byte
- NONCE_BYTES, 8, payload length in bytes (1..32)
- TIMEOUT_CYCLES, 1000000, idle cycles tolerated between bytes once inside a frame (>=2)
- TO_W, $clog2(TIMEOUT_CYCLES), timeout counter width (derived)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- new_data_i  in  1  one-cycle strobe, data_i valid
- data_i  in  8  received byte
- nonce_ready_i  in  1  downstream accepts nonce
- start_o  out  1  one-cycle pulse, command '1'
- stop_o  out  1  one-cycle pulse, command '0'
- ping_o  out  1  one-cycle pulse, command 'p'
- nonce_valid_o  out  1  nonce_o valid, held until accepted
- nonce_o  out  8*NONCE_BYTES  captured nonce, first byte in MSBs
- busy_o  out  1  high in any state except S_HDR0
- error_o  out  1  one-cycle pulse on timeout, unknown command or checksum failure

Behaviour:
- Reset: state S_HDR0; all pulses, nonce_valid_o, busy_o, error_o = 0; nonce_o = 0; timeout counter = 0; byte counter = 0.
- All outputs registered. Pulses assert the cycle after the accepting clock edge.
- S_HDR0: byte == HDR0 goes to S_HDR1; any other byte is ignored and causes no error.
- S_HDR1: HDR1 goes to S_CMD. HDR0 stays in S_HDR1 (re-sync). Any other byte returns to S_HDR0 silently.
- S_CMD:
  - '1', '0', 'p' issue their pulse and go to S_HDR0.
  - 'n' clears the byte counter and goes to S_PAYLOAD.
  - Any other byte pulses error_o and goes to S_HDR0.
- S_PAYLOAD: each byte shifts into a shadow register (left shift, new byte into LSBs). After NONCE_BYTES bytes, shadow copies to nonce_o, nonce_valid_o is set, and the FSM goes to S_HOLD.
- S_HOLD:
  - nonce_valid_o held high and nonce_o stable until nonce_ready_i samples high.
  - On that edge nonce_valid_o clears and the FSM goes to S_HDR0.
  - new_data_i is dropped while in S_HOLD, with no error.
  - If ready is already high on the cycle valid first rises, the transfer completes on the next edge.
- Timeout:
  - Counter clears on every accepted byte and on entry to S_HDR1, S_CMD and S_PAYLOAD. It counts in S_HDR1, S_CMD and S_PAYLOAD only.
  - Reaching TIMEOUT_CYCLES-1 sends the FSM to S_HDR0 and pulses error_o.
  - Timeout and new_data_i in the same cycle: timeout wins and the byte is discarded.
- nonce_o keeps its last accepted value outside S_HOLD. A partial payload never reaches nonce_o.
- Reset asserted mid-frame or in S_HOLD: immediate return to reset values; any pending nonce is lost.

Optional Feature:
- Macro: CMD_CHECKSUM_EN.
- When defined:
  - One check byte follows the command byte (start/stop/ping) or the last payload byte (nonce), handled in state S_CHECK.
  - Check byte must equal the XOR of the command byte and all payload bytes.
  - Match: issue the pulse, or load nonce_o and enter S_HOLD.
  - Mismatch: error_o pulse, nonce_o unchanged, return to S_HDR0.
  - Timeout applies in S_CHECK.
- When undefined: no S_CHECK state, and actions occur exactly as described above.

Decomposition:
- Package cmd_rx_pkg holds:
  - state enum: S_HDR0, S_HDR1, S_CMD, S_PAYLOAD, S_CHECK, S_HOLD
  - command byte constants: CMD_START=8'd49, CMD_STOP=8'd48, CMD_PING=8'd112, CMD_NONCE=8'd110
- Sub-module idle_timeout_counter (params CYCLES, W; ports clk_i, rst_i, clear_i, enable_i, expired_o) holds the timeout logic. Everything else stays in the top.

Test Plan:
- Bytes 100,52,49 -> start_o pulses once, one cycle after the 49 strobe; busy_o returns to 0; no error_o.
- Bytes 100,100,52,112 -> ping_o pulse (header re-sync). Bytes 100,52,120 -> error_o pulse, no command pulse.
- NONCE_BYTES=4, bytes 100,52,110,0x12,0x34,0x56,0x78 with nonce_ready_i low for 10 cycles -> nonce_o=0x12345678, nonce_valid_o high for 10+ cycles, extra bytes during hold ignored; raise ready -> valid drops next edge.
- TIMEOUT_CYCLES=16, bytes 100,52,110,0xAA then silence -> error_o pulse exactly 16 cycles after the 0xAA strobe, FSM in S_HDR0, nonce_o unchanged.
- Timeout cycle coincident with a new_data_i=49 strobe in S_CMD -> no start_o, error_o pulses.
- Reset asserted during payload byte 2 -> all outputs 0 asynchronously. With CMD_CHECKSUM_EN: bytes 100,52,49,0x31 -> start_o; bytes 100,52,49,0x30 -> error_o.
